round_robin_arbiter: RTL and testbench
======================================

ROUND_ROBIN_ARBITER -- requirements
Module: round_robin_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, 16, maximum consecutive cycles one requester may hold the grant; legal range 2..256.
REQ-002 Port: clock  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: request  input  4  per-requester request; bit i high = requester i wants or is using the shared resource.
REQ-005 Port: valid  output  1  high when a grant is active.
REQ-006 Port: user  output  2  index of the granted requester; 0 when valid is low.
REQ-007 Port: grant  output  4  one-hot of user when valid is high; 4'b0000 otherwise.
REQ-008 Port: expired  output  1  one-cycle pulse when a grant is revoked by the MAX_HOLD limit.

Function
REQ-009 All outputs SHALL be registered; no combinational path from request to any output.
REQ-010 State machine SHALL have two states: IDLE (valid=0) and GRANTED (valid=1).
REQ-011 Internal state SHALL include last (2 bits, most recently granted index) and hold_cnt (counts 0..MAX_HOLD-1).
REQ-012 Round-robin pick SHALL select the first asserted request bit in order last+1, last+2, last+3, last (mod 4).
REQ-013 IDLE, request==0: remain in IDLE; outputs unchanged.
REQ-014 IDLE, request!=0: at that edge, grant the round-robin pick, set last to the pick, set hold_cnt=0, enter GRANTED; latency from request sampled to valid high = 1 cycle.
REQ-015 GRANTED, request[user]==1 and hold_cnt<MAX_HOLD-1: hold grant; hold_cnt increments by 1.
REQ-016 GRANTED, request[user]==0 (release): at that edge, re-arbitrate among the remaining requests with no idle cycle; if none, enter IDLE with valid=0, user=0, grant=0.
REQ-017 GRANTED, request[user]==1 and hold_cnt==MAX_HOLD-1 (timeout): pulse expired for one cycle; grant the round-robin pick excluding user; if no other request, regrant the same user with hold_cnt=0.
REQ-018 Every new or renewed grant SHALL reset hold_cnt to 0 and set last to the granted index.
REQ-019 A granted requester SHALL therefore hold grant for at most MAX_HOLD consecutive cycles while others request.
REQ-020 Request bits SHALL be sampled only at clock edges; glitches between edges are ignored.
REQ-021 Simultaneous release by user and new request from others SHALL be treated as REQ-016 in the same edge.
REQ-022 expired SHALL be low in every cycle not directly following a timeout edge.

Reset
REQ-023 reset_n low SHALL immediately (asynchronously) force state=IDLE, valid=0, user=0, grant=4'b0000, expired=0, hold_cnt=0, last=3.
REQ-024 With last=3 after reset, the first arbitration SHALL favour requester 0.
REQ-025 Reset asserted mid-grant SHALL drop the grant immediately; the first grant after deassertion follows REQ-014 and REQ-024.
REQ-026 Outputs SHALL remain at reset values until the first rising edge after reset_n goes high.

Verification
REQ-027 After reset, request=4'b1010 for one edge -> next cycle valid=1, user=1, grant=4'b0010.
REQ-028 Requests 0 and 2 held, each dropped after 3 granted cycles -> grants alternate 0,2,0,2 with no idle cycle between them.
REQ-029 MAX_HOLD=4, request=4'b0011 held continuously -> user 0 for 4 cycles, expired pulse, user 1 for 4 cycles, expired pulse, user 0 again.
REQ-030 MAX_HOLD=4, only request[3] held -> valid stays 1, user=3, expired pulses every 4 cycles.
REQ-031 request goes 4'b0000 while GRANTED -> next cycle valid=0, user=0, grant=4'b0000.
REQ-032 reset_n pulsed low mid-grant between edges -> outputs zero immediately; after release with request=4'b1111, first grant is user 0.

Source files
------------

// File: rtl/round_robin_arbiter.sv
// Four-requester round-robin arbiter with a per-grant hold limit.
// Outputs are registered; a requester loses the grant after MAX_HOLD cycles when others wait.
module round_robin_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] request,
    output logic       valid,
    output logic [1:0] user,
    output logic [3:0] grant,
    output logic       expired
);

    // state   | meaning
    // IDLE    | no grant active, valid=0, user=0, grant=0
    // GRANTED | user owns the resource, hold_cnt counts its cycles

    localparam int CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       last_q, last_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             valid_q, valid_d;
    logic [1:0]       user_q, user_d;
    logic [3:0]       grant_q, grant_d;
    logic             expired_q, expired_d;

    logic [1:0] pick_all;
    logic       found_all;
    logic [1:0] pick_other;
    logic       found_other;
    logic [1:0] cand;

    // Search order starts one past the last winner; pick_other never wraps back to last.
    always_comb begin
        pick_all    = last_q;
        found_all   = 1'b0;
        pick_other  = last_q;
        found_other = 1'b0;
        cand        = last_q;
        for (int i = 1; i <= 4; i++) begin
            cand = last_q + 2'(i);
            if (!found_all && request[cand]) begin
                found_all = 1'b1;
                pick_all  = cand;
            end
            if (i < 4 && !found_other && request[cand]) begin
                found_other = 1'b1;
                pick_other  = cand;
            end
        end
    end

    logic       do_grant;
    logic       go_idle;
    logic [1:0] grant_idx;

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        valid_d    = valid_q;
        user_d     = user_q;
        grant_d    = grant_q;
        expired_d  = 1'b0;
        do_grant   = 1'b0;
        go_idle    = 1'b0;
        grant_idx  = last_q;

        case (state_q)
            IDLE: begin
                if (found_all) begin
                    do_grant  = 1'b1;
                    grant_idx = pick_all;
                end
            end
            GRANTED: begin
                if (!request[user_q]) begin
                    if (found_all) begin
                        do_grant  = 1'b1;
                        grant_idx = pick_all;
                    end else begin
                        go_idle = 1'b1;
                    end
                end else if (hold_cnt_q == HOLD_LAST) begin
                    // Timeout: hand over if anyone else waits, otherwise renew the same user.
                    expired_d = 1'b1;
                    do_grant  = 1'b1;
                    grant_idx = found_other ? pick_other : user_q;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: go_idle = 1'b1;
        endcase

        if (do_grant) begin
            state_d    = GRANTED;
            valid_d    = 1'b1;
            user_d     = grant_idx;
            grant_d    = 4'b0001 << grant_idx;
            last_d     = grant_idx;
            hold_cnt_d = '0;
        end

        if (go_idle) begin
            state_d    = IDLE;
            valid_d    = 1'b0;
            user_d     = 2'd0;
            grant_d    = 4'b0000;
            hold_cnt_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            last_q     <= 2'd3;
            hold_cnt_q <= '0;
            valid_q    <= 1'b0;
            user_q     <= 2'd0;
            grant_q    <= 4'b0000;
            expired_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
            valid_q    <= valid_d;
            user_q     <= user_d;
            grant_q    <= grant_d;
            expired_q  <= expired_d;
        end
    end

    assign valid   = valid_q;
    assign user    = user_q;
    assign grant   = grant_q;
    assign expired = expired_q;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Bench for round_robin_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a tenure-based reference model.
module tb_round_robin_arbiter;

    localparam int MAX_HOLD = 4;

    logic       clock;
    logic       reset_n;
    logic [3:0] request;
    logic       valid;
    logic [1:0] user;
    logic [3:0] grant;
    logic       expired;

    round_robin_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .request (request),
        .valid   (valid),
        .user    (user),
        .grant   (grant),
        .expired (expired)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: tracks who owns the resource and for how many visible cycles.
    int m_valid, m_user, m_last, m_tenure, m_expired;

    function automatic int rr_first(input logic [3:0] req, input int from, input int skip_self);
        int span = skip_self ? 3 : 4;
        for (int k = 1; k <= span; k++) begin
            if (req[(from + k) % 4]) return (from + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_user = 0; m_last = 3; m_tenure = 0; m_expired = 0;
    endtask

    task automatic model_give(input int who);
        m_valid = 1; m_user = who; m_last = who; m_tenure = 1;
    endtask

    task automatic model_edge(input logic [3:0] req);
        int w;
        m_expired = 0;
        if (m_valid == 0) begin
            if (req != 0) model_give(rr_first(req, m_last, 0));
        end else if (!req[m_user]) begin
            w = rr_first(req, m_last, 0);
            if (w < 0) begin
                m_valid = 0; m_user = 0; m_tenure = 0;
            end else begin
                model_give(w);
            end
        end else if (m_tenure == MAX_HOLD) begin
            m_expired = 1;
            w = rr_first(req, m_user, 1);
            model_give(w < 0 ? m_user : w);
        end else begin
            m_tenure++;
        end
    endtask

    task automatic compare_all();
        chk("valid",   int'(valid),   m_valid);
        chk("user",    int'(user),    m_user);
        chk("grant",   int'(grant),   m_valid ? (1 << m_user) : 0);
        chk("expired", int'(expired), m_expired);
    endtask

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) model_reset();
        else          model_edge(request);
        #1;
        if (check_en) compare_all();
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        #1 reset_n = 1'b0;
        #3 reset_n = 1'b1;
    endtask

    int exp_user;
    logic [3:0] save;

    initial begin
        reset_n = 1'b1;
        request = 4'b0000;
        model_reset();
        #2 reset_n = 1'b0;
        #1;
        check_en = 1'b1;
        #10;
        chk("reset_valid", int'(valid), 0);
        chk("reset_grant", int'(grant), 0);
        chk("model_reset_last", m_last, 3);
        @(posedge clock);
        #3 reset_n = 1'b1;
        #1 chk("post_reset_hold", int'(valid), 0);

        // Requesters 1 and 3: after reset the search starts at 0, so 1 wins.
        request = 4'b1010;
        tick();
        chk("r1010_valid", int'(valid), 1);
        chk("r1010_user",  int'(user),  1);
        chk("r1010_grant", int'(grant), 4'b0010);
        chk("model_r1010_user", m_user, 1);

        request = 4'b0000;
        tick();
        chk("drop_valid", int'(valid), 0);
        chk("drop_user",  int'(user),  0);
        chk("drop_grant", int'(grant), 0);

        // Alternation 0,2,0,2 with three cycles each and no idle gap.
        do_reset();
        request = 4'b0101;
        tick();
        for (int r = 0; r < 4; r++) begin
            exp_user = (r % 2 == 0) ? 0 : 2;
            for (int c = 1; c <= 3; c++) begin
                chk("alt_valid", int'(valid), 1);
                chk("alt_user",  int'(user),  exp_user);
                request = (c == 3) ? (4'b0101 & ~(4'b0001 << exp_user)) : 4'b0101;
                tick();
            end
        end

        // Two requesters held continuously: four cycles each, expired on each handover.
        do_reset();
        request = 4'b0011;
        tick();
        for (int k = 1; k <= 9; k++) begin
            chk("to_user",    int'(user),    (k <= 4 || k == 9) ? 0 : 1);
            chk("to_expired", int'(expired), (k == 5 || k == 9) ? 1 : 0);
            if (k == 5) chk("model_to_user", m_user, 1);
            tick();
        end

        // Single requester: renewed every four cycles, valid never drops.
        do_reset();
        request = 4'b1000;
        tick();
        for (int k = 1; k <= 13; k++) begin
            chk("solo_valid",   int'(valid),   1);
            chk("solo_user",    int'(user),    3);
            chk("solo_expired", int'(expired), (k > 1 && (k - 1) % 4 == 0) ? 1 : 0);
            tick();
        end

        // Reset between edges while granted.
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_valid",   int'(valid),   0);
        chk("midrst_grant",   int'(grant),   0);
        chk("midrst_user",    int'(user),    0);
        chk("midrst_expired", int'(expired), 0);
        #2 reset_n = 1'b1;
        request = 4'b1111;
        tick();
        chk("midrst_first_user",  int'(user),  0);
        chk("midrst_first_valid", int'(valid), 1);

        // Random traffic with glitches between edges and occasional async resets.
        for (int n = 0; n < 600; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r >= 6 && r < 9) request = 4'($urandom_range(0, 15));
            else if (r == 9)     request = 4'b0000;
            if ($urandom_range(0, 3) == 0) begin
                save = request;
                #1 request = ~save;
                #1 request = save;
            end
            if ($urandom_range(0, 63) == 0) begin
                #1 reset_n = 1'b0;
                #2 reset_n = 1'b1;
            end
            tick();
        end

        #5;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
